// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register: control-bit map,
// flush/reset defaults and the occupancy state decode used by the stage control.
package pipe_pkg;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREG   = 1;
    localparam int CTRL_JAL      = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_ERR      = 4;
    localparam int CTRL_HALT     = 5;
    localparam int CTRL_STALL_MC = 6;
    localparam int CTRL_SPARE    = 7;

    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
    // HALT must survive a squash so the core still stops after a flush.
    localparam logic [7:0]  KEEP_MASK_DEFAULT = 8'(1 << CTRL_HALT);

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_ONE     = 2'd1,
        OCC_FULL    = 2'd2,
        OCC_ILLEGAL = 2'd3
    } occ_state_e;

    function automatic occ_state_e stage_state(input logic m_valid, input logic s_valid);
        case ({s_valid, m_valid})
            2'b00:   return OCC_EMPTY;
            2'b01:   return OCC_ONE;
            2'b11:   return OCC_FULL;
            default: return OCC_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the stage register (valid, data, ctrl, instr).
// Priority: reset, then clear-with-keep-mask, then load, then drop, else hold.
module pipe_slot #(
    parameter int                   DATA_W    = 48,
    parameter int                   CTRL_W    = 8,
    parameter int                   INSTR_W   = 16,
    parameter logic [CTRL_W-1:0]    KEEP_MASK = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               drop,
    input  logic [DATA_W-1:0]  d_data,
    input  logic [CTRL_W-1:0]  d_ctrl,
    input  logic [INSTR_W-1:0] d_instr,
    output logic               valid,
    output logic [DATA_W-1:0]  data,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [INSTR_W-1:0] instr
);

    logic               valid_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [CTRL_W-1:0]  ctrl_reg;
    logic [INSTR_W-1:0] instr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
            instr_reg <= NOP_INSTR;
        end else if (clear) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ctrl_reg  <= ctrl_reg & KEEP_MASK;
            instr_reg <= NOP_INSTR;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= d_data;
            ctrl_reg  <= d_ctrl;
            instr_reg <= d_instr;
        end else if (drop) begin
            // Payload fields are left untouched; only the valid bit retires.
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign ctrl  = ctrl_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid (main M, skid S)
// and flush with keep mask. Define STAGE_PERF_CNT_EN to add stall/flush counters.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 48,
    parameter int                 CTRL_W    = 8,
    parameter logic [CTRL_W-1:0]  KEEP_MASK = CTRL_W'(KEEP_MASK_DEFAULT),
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic [1:0]         occupancy
`ifdef STAGE_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int SLOT_M = 0;
    localparam int SLOT_S = 1;

    logic [1:0]                slot_load;
    logic [1:0]                slot_drop;
    logic [1:0]                slot_valid;
    logic [1:0][DATA_W-1:0]    slot_d_data;
    logic [1:0][CTRL_W-1:0]    slot_d_ctrl;
    logic [1:0][INSTR_W-1:0]   slot_d_instr;
    logic [1:0][DATA_W-1:0]    slot_data;
    logic [1:0][CTRL_W-1:0]    slot_ctrl;
    logic [1:0][INSTR_W-1:0]   slot_instr;

    logic       acc;
    logic       pop;
    occ_state_e occ_state;

    assign in_ready  = !slot_valid[SLOT_S] && !flush;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occ_state = stage_state(slot_valid[SLOT_M], slot_valid[SLOT_S]);

    // M refills from S whenever S holds the older beat; S only ever takes input.
    assign slot_d_data[SLOT_M]  = slot_valid[SLOT_S] ? slot_data[SLOT_S]  : in_data;
    assign slot_d_ctrl[SLOT_M]  = slot_valid[SLOT_S] ? slot_ctrl[SLOT_S]  : in_ctrl;
    assign slot_d_instr[SLOT_M] = slot_valid[SLOT_S] ? slot_instr[SLOT_S] : in_instr;
    assign slot_d_data[SLOT_S]  = in_data;
    assign slot_d_ctrl[SLOT_S]  = in_ctrl;
    assign slot_d_instr[SLOT_S] = in_instr;

    always_comb begin
        slot_load = '0;
        slot_drop = '0;
        case (occ_state)
            OCC_EMPTY: begin
                slot_load[SLOT_M] = acc;
            end
            OCC_ONE: begin
                if (pop && acc) begin
                    slot_load[SLOT_M] = 1'b1;
                end else if (pop) begin
                    slot_drop[SLOT_M] = 1'b1;
                end else if (acc) begin
                    slot_load[SLOT_S] = 1'b1;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    slot_load[SLOT_M] = 1'b1;
                    slot_drop[SLOT_S] = 1'b1;
                end
            end
            default: begin
                slot_drop = 2'b11;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        pipe_slot #(
            .DATA_W    (DATA_W),
            .CTRL_W    (CTRL_W),
            .INSTR_W   (INSTR_W),
            .KEEP_MASK (KEEP_MASK),
            .NOP_INSTR (NOP_INSTR)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (slot_load[gi]),
            .clear   (flush),
            .drop    (slot_drop[gi]),
            .d_data  (slot_d_data[gi]),
            .d_ctrl  (slot_d_ctrl[gi]),
            .d_instr (slot_d_instr[gi]),
            .valid   (slot_valid[gi]),
            .data    (slot_data[gi]),
            .ctrl    (slot_ctrl[gi]),
            .instr   (slot_instr[gi])
        );
    end

    assign out_valid = slot_valid[SLOT_M];
    assign out_data  = slot_data[SLOT_M];
    assign out_ctrl  = slot_ctrl[SLOT_M];
    assign out_instr = slot_instr[SLOT_M];
    assign occupancy = {1'b0, slot_valid[SLOT_M]} + {1'b0, slot_valid[SLOT_S]};

    a_no_skid_without_main : assert property (
        @(posedge clk) disable iff (rst) !(slot_valid[SLOT_S] && !slot_valid[SLOT_M])
    );

`ifdef STAGE_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (flush && flush_cnt_reg != 16'hFFFF) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule
